// File: rtl/bp_fpga_host_uart_tx.sv
// bp_fpga_host_uart_tx
//   UART transmitter for the FPGA host output path. It sends LSB first, with
//   configurable data, parity and stop bits. Frames can run back to back with
//   no idle gap between them. tx_o comes straight from a flop.
//   Optional feature: define BP_FPGA_HOST_UART_TX_CTS_EN to add the cts_n_i
//   clear-to-send input. That input goes through a 2-flop synchronizer and
//   gates the start of each new frame.
module bp_fpga_host_uart_tx #(
   parameter int clk_per_bit_p = 10416,
   parameter int data_bits_p   = 8,
   parameter int parity_bit_p  = 0,
   parameter int parity_odd_p  = 0,
   parameter int stop_bits_p   = 1
) (
   input  logic                   clk_i,
   input  logic                   reset_n_i,
`ifdef BP_FPGA_HOST_UART_TX_CTS_EN
   input  logic                   cts_n_i,
`endif
   input  logic                   tx_v_i,
   input  logic [data_bits_p-1:0] tx_i,
   output logic                   tx_ready_and_o,
   output logic                   tx_v_o,
   output logic                   tx_o,
   output logic                   tx_done_o
);

   localparam int baud_w_lp = $clog2(clk_per_bit_p);
   localparam int bit_w_lp  = $clog2(data_bits_p + 1);
   localparam logic [baud_w_lp-1:0] baud_max_lp = baud_w_lp'(clk_per_bit_p - 1);
   localparam logic [bit_w_lp-1:0]  bit_last_lp = bit_w_lp'(data_bits_p - 1);
   localparam logic                 stop_last_lp = 1'(stop_bits_p - 1);
   localparam logic                 parity_odd_lp = 1'(parity_odd_p);

   // Reject illegal parameter values during elaboration.
   if (clk_per_bit_p < 2) begin : g_bad_clk_per_bit
      $error("clk_per_bit_p must be >= 2");
   end
   if (data_bits_p < 5 || data_bits_p > 9) begin : g_bad_data_bits
      $error("data_bits_p must be 5..9");
   end
   if (parity_bit_p < 0 || parity_bit_p > 1) begin : g_bad_parity_bit
      $error("parity_bit_p must be 0 or 1");
   end
   if (parity_odd_p < 0 || parity_odd_p > 1) begin : g_bad_parity_odd
      $error("parity_odd_p must be 0 or 1");
   end
   if (stop_bits_p < 1 || stop_bits_p > 2) begin : g_bad_stop_bits
      $error("stop_bits_p must be 1..2");
   end

   typedef enum logic [2:0] {
      e_idle,
      e_start,
      e_data,
      e_parity,
      e_stop
   } state_e;

   state_e                   state_r, state_n;
   logic [baud_w_lp-1:0]     baud_r, baud_n;
   logic [bit_w_lp-1:0]      bit_cnt_r, bit_cnt_n;
   logic                     stop_cnt_r, stop_cnt_n;
   logic [data_bits_p-1:0]   shift_r, shift_n;
   logic                     parity_r, parity_n;
   logic                     tx_r, tx_n;
   logic                     out_of_reset_r;
   logic                     cts_ok;
   logic                     bit_end;
   logic                     last_stop;
   logic                     accept;

`ifdef BP_FPGA_HOST_UART_TX_CTS_EN
   logic [1:0] cts_sync_r;

   // Bring cts_n_i into the clk_i domain. The reset value is "not clear to send".
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) cts_sync_r <= 2'b11;
      else            cts_sync_r <= {cts_sync_r[0], cts_n_i};
   end

   assign cts_ok = ~cts_sync_r[1];
`else
   assign cts_ok = 1'b1;
`endif

   // Hold ready low until the first clock edge after reset is released.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) out_of_reset_r <= 1'b0;
      else            out_of_reset_r <= 1'b1;
   end

   assign bit_end   = (baud_r == '0);
   assign last_stop = (stop_cnt_r == stop_last_lp);

   assign tx_ready_and_o = out_of_reset_r & cts_ok &
                           ((state_r == e_idle) | ((state_r == e_stop) & last_stop & bit_end));
   assign accept         = tx_v_i & tx_ready_and_o;
   assign tx_v_o         = (state_r != e_idle);
   assign tx_done_o      = (state_r == e_stop) & last_stop & bit_end;
   assign tx_o           = tx_r;

   // Compute next-state logic, the baud and bit counters, and the next line level.
   always_comb begin
      // NOTE: every signal gets a default first. Any branch that skips an
      // assignment then keeps the old value instead of inferring a latch.
      state_n    = state_r;
      baud_n     = bit_end ? baud_max_lp : baud_r - 1'b1;
      bit_cnt_n  = bit_cnt_r;
      stop_cnt_n = stop_cnt_r;
      shift_n    = shift_r;
      parity_n   = parity_r;
      tx_n       = 1'b1;

      unique case (state_r)
         e_idle: begin
            baud_n = baud_max_lp;
            if (accept) begin
               state_n  = e_start;
               shift_n  = tx_i;
               parity_n = ^tx_i ^ parity_odd_lp;
               tx_n     = 1'b0;
            end
         end
         e_start: begin
            tx_n = 1'b0;
            if (bit_end) begin
               state_n   = e_data;
               bit_cnt_n = '0;
               tx_n      = shift_r[0];
            end
         end
         e_data: begin
            tx_n = shift_r[0];
            if (bit_end) begin
               shift_n   = shift_r >> 1;
               bit_cnt_n = bit_cnt_r + 1'b1;
               tx_n      = shift_r[1];
               if (bit_cnt_r == bit_last_lp) begin
                  if (parity_bit_p != 0) begin
                     state_n = e_parity;
                     tx_n    = parity_r;
                  end else begin
                     state_n    = e_stop;
                     stop_cnt_n = 1'b0;
                     tx_n       = 1'b1;
                  end
               end
            end
         end
         e_parity: begin
            tx_n = parity_r;
            if (bit_end) begin
               state_n    = e_stop;
               stop_cnt_n = 1'b0;
               tx_n       = 1'b1;
            end
         end
         e_stop: begin
            if (bit_end) begin
               if (!last_stop) begin
                  stop_cnt_n = stop_cnt_r + 1'b1;
               end else if (accept) begin
                  // A new byte arrives in the final stop cycle, so start the next frame with no gap.
                  state_n  = e_start;
                  shift_n  = tx_i;
                  parity_n = ^tx_i ^ parity_odd_lp;
                  tx_n     = 1'b0;
               end else begin
                  state_n = e_idle;
               end
            end
         end
         default: state_n = e_idle;
      endcase
   end

   // Register the state and the line. Reset truncates any frame in flight.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      // NOTE: sequential state uses non-blocking assignments only. All flops
      // then update together, however the statements are ordered.
      if (!reset_n_i) begin
         state_r    <= e_idle;
         baud_r     <= '0;
         bit_cnt_r  <= '0;
         stop_cnt_r <= 1'b0;
         shift_r    <= '0;
         parity_r   <= 1'b0;
         tx_r       <= 1'b1;
      end else begin
         state_r    <= state_n;
         baud_r     <= baud_n;
         bit_cnt_r  <= bit_cnt_n;
         stop_cnt_r <= stop_cnt_n;
         shift_r    <= shift_n;
         parity_r   <= parity_n;
         tx_r       <= tx_n;
      end
   end

endmodule
